eth_recv_frontend: RTL and testbench
====================================

Name: eth_recv_frontend

Overview:
- Serial front end of the Ethernet receive path.
- Deserializes the LSB-first byte stream arriving on recv_sck/recv_mosi/n_recv_ss from the network interface MCU.
- Filters frames by station MAC, then streams accepted bytes as write strobes into the downstream receive buffer and status block (buffer at F000h, length register, CR full bit).
- Reports each frame end as either done (buffer marks full, latches length) or drop.

Parameters:
- MAC, 48'hEAEEF2F6FAFE, station address; byte 0 of the frame compares to MAC[7:0], byte 5 to MAC[47:40].
- ADDR_W, 11, buffer address width.
- BUF_SIZE, 2048, buffer capacity in bytes.

Ports:
- clk  input  1  system clock.
- n_rst  input  1  asynchronous active-low reset.
- recv_sck  input  1  serial clock, asynchronous to clk; data sampled on rising edge.
- recv_mosi  input  1  serial data, LSB first.
- n_recv_ss  input  1  frame envelope, active low, asynchronous.
- buf_full  input  1  downstream buffer holds an unread frame (CR bit 0).
- wr_en  output  1  one-cycle byte write strobe.
- wr_addr  output  ADDR_W  byte index within the frame.
- wr_data  output  8  received byte.
- frame_done  output  1  one-cycle pulse: frame accepted.
- frame_len  output  ADDR_W  valid with frame_done: index of last byte written (byte count − 1).
- frame_drop  output  1  one-cycle pulse: frame rejected.

Behaviour:
- Reset values: wr_en, frame_done and frame_drop are 0; wr_addr, wr_data and frame_len are 0; state is WAIT_IDLE.
- Input synchronization:
  - recv_sck, recv_mosi and n_recv_ss each pass through a 2-flop synchronizer.
  - mosi passes through the same depth as sck, so the synchronized mosi is sampled on the detected synchronized sck rising edge.
  - Requirement: sck high and low phases ≥ 3 clk periods each.
- Bit assembly: a shift register fills LSB first. The bit counter resets on each n_ss falling edge. On the 8th bit a byte completes.
- Byte write: wr_en pulses with wr_addr = byte count and wr_data = byte, at most 4 clk after the completing sck rising edge at the pins.
- States:
  - WAIT_IDLE: entered at reset; waits for synchronized n_ss = 1, then goes to IDLE. This prevents accepting a frame already in progress at reset release.
  - IDLE: on n_ss fall, latch buf_full. If 1 → DISCARD; else → HDR with count = 0.
  - HDR: bytes 0–5 are written and compared to MAC.
    - Any mismatch → DISCARD. The mismatching byte is still written; later bytes are not.
    - Byte 5 matching → BODY.
  - BODY: bytes written at increasing wr_addr. When a byte completes with count = BUF_SIZE (overflow) → DISCARD, and no write occurs.
  - DISCARD: no writes; ignores all bits until n_ss rises.
- Frame end (synchronized n_ss rising edge), one clk later:
  - From BODY: frame_done = 1 and frame_len = count − 1. Any partial trailing byte (bit counter ≠ 0) is discarded silently.
  - From HDR (fewer than 6 bytes): frame_drop = 1.
  - From DISCARD: frame_drop = 1.
  - Next state is IDLE in all cases.
- Acceptance is decided only at frame start:
  - buf_full going 0 mid-frame does not rescue a discarded frame.
  - buf_full going 1 mid-frame does not abort an accepted frame.
- n_ss rising and a byte completing in the same clk: the byte write occurs first; the frame-end pulse follows one cycle later and includes that byte.
- Asynchronous reset mid-frame: all outputs drop to their reset values immediately; no done/drop pulse is issued for the interrupted frame.
- The count register is ADDR_W+1 bits, so the overflow check cannot wrap.

Test Plan:
- Frame FE FA F6 F2 EE EA AA 55 73 87, buf_full = 0 → 10 writes at addr 0..9 with matching data; frame_done with frame_len = 9; no frame_drop.
- Same frame with byte 2 = F5 → writes at addr 0..2 only; frame_drop pulse; no frame_done.
- buf_full = 1 at n_ss fall, deasserted after byte 9 of a 14-byte matching frame → zero writes, frame_drop. Next 13-byte frame with buf_full = 0 → frame_done, frame_len = 12, 13 writes.
- 4-byte frame FE FA F6 F2 → 4 writes, then frame_drop.
- 2050-byte matching frame → writes at addr 0..2047; byte 2048 not written; frame_drop.
- Assert n_rst low during byte 8 of a frame, release while n_ss is still low → no writes or pulses for the rest of that frame; the following frame is accepted normally (frame_done).

Source files
------------

// File: rtl/eth_recv_frontend.sv
// Ethernet receive front end: deserializes the LSB-first serial stream from the
// network interface MCU, filters frames on the station MAC and streams accepted
// bytes as write strobes into the receive buffer, reporting done or drop at
// the end of each frame.
module eth_recv_frontend #(
   parameter logic [47:0] MAC      = 48'hEAEEF2F6FAFE,
   parameter int          ADDR_W   = 11,
   parameter int          BUF_SIZE = 2048
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              recv_sck,
   input  logic              recv_mosi,
   input  logic              n_recv_ss,
   input  logic              buf_full,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic              frame_done,
   output logic [ADDR_W-1:0] frame_len,
   output logic              frame_drop
);

   localparam int CNT_W = ADDR_W + 1;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BUF_SIZE);
   localparam logic [CNT_W-1:0] CNT_LAST_HDR = CNT_W'(5);

   typedef enum logic [2:0] {
      WAIT_IDLE,
      IDLE,
      HDR,
      BODY,
      DISCARD
   } state_t;

   logic [1:0] sck_sync;
   logic [1:0] mosi_sync;
   logic [1:0] nss_sync;
   logic       sck_prev;
   logic       nss_prev;

   logic       sck_s;
   logic       mosi_s;
   logic       nss_s;
   logic       sck_rise;
   logic       nss_fall;
   logic       nss_rise;

   logic [2:0] bit_cnt;
   logic [6:0] shreg;
   logic       byte_done;
   logic [7:0] byte_val;

   state_t           state, state_n;
   logic [CNT_W-1:0] count, count_n;
   logic [CNT_W-1:0] count_m1;
   logic             end_pend, end_pend_n;
   logic [7:0]       mac_byte;

   logic              wr_en_n;
   logic [ADDR_W-1:0] wr_addr_n;
   logic [7:0]        wr_data_n;
   logic              frame_done_n;
   logic [ADDR_W-1:0] frame_len_n;
   logic              frame_drop_n;

   // Two-flop synchronizers plus previous-value flops for edge detection.
   // The select line resets to "asserted" so a frame already in progress at
   // reset release never produces a falling edge and is never accepted.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         sck_sync  <= 2'b00;
         mosi_sync <= 2'b00;
         nss_sync  <= 2'b00;
         sck_prev  <= 1'b0;
         nss_prev  <= 1'b0;
      end else begin
         sck_sync  <= {sck_sync[0], recv_sck};
         mosi_sync <= {mosi_sync[0], recv_mosi};
         nss_sync  <= {nss_sync[0], n_recv_ss};
         sck_prev  <= sck_sync[1];
         nss_prev  <= nss_sync[1];
      end
   end

   assign sck_s    = sck_sync[1];
   assign mosi_s   = mosi_sync[1];
   assign nss_s    = nss_sync[1];
   assign sck_rise = sck_s & ~sck_prev;
   assign nss_fall = ~nss_s & nss_prev;
   assign nss_rise = nss_s & ~nss_prev;

   assign byte_done = sck_rise & ~nss_s & (bit_cnt == 3'd7);
   assign byte_val  = {mosi_s, shreg};
   assign count_m1  = count - CNT_ONE;

   // Bit assembly: shift in LSB first, restarting the bit count at frame start.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         bit_cnt <= 3'd0;
         shreg   <= 7'd0;
      end else if (nss_fall) begin
         bit_cnt <= 3'd0;
      end else if (sck_rise && !nss_s) begin
         bit_cnt <= bit_cnt + 3'd1;
         shreg   <= {mosi_s, shreg[6:1]};
      end
   end

   // Frame state machine registers and registered outputs.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state      <= WAIT_IDLE;
         count      <= '0;
         end_pend   <= 1'b0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= 8'd0;
         frame_done <= 1'b0;
         frame_len  <= '0;
         frame_drop <= 1'b0;
      end else begin
         state      <= state_n;
         count      <= count_n;
         end_pend   <= end_pend_n;
         wr_en      <= wr_en_n;
         wr_addr    <= wr_addr_n;
         wr_data    <= wr_data_n;
         frame_done <= frame_done_n;
         frame_len  <= frame_len_n;
         frame_drop <= frame_drop_n;
      end
   end

   // Next-state logic. A frame end is noted in end_pend and resolved one cycle
   // later, so a byte completing together with the select rise is written and
   // counted before the done/drop decision is taken.
   always_comb begin
      state_n      = state;
      count_n      = count;
      end_pend_n   = 1'b0;
      wr_en_n      = 1'b0;
      wr_addr_n    = wr_addr;
      wr_data_n    = wr_data;
      frame_done_n = 1'b0;
      frame_len_n  = frame_len;
      frame_drop_n = 1'b0;
      mac_byte     = 8'(MAC >> {count[2:0], 3'b000});

      if (end_pend) begin
         state_n = IDLE;
         if (state == BODY) begin
            frame_done_n = 1'b1;
            frame_len_n  = count_m1[ADDR_W-1:0];
         end else begin
            frame_drop_n = 1'b1;
         end
      end else begin
         case (state)
            WAIT_IDLE: begin
               if (nss_s) state_n = IDLE;
            end
            IDLE: begin
               if (nss_fall) begin
                  count_n = '0;
                  state_n = buf_full ? DISCARD : HDR;
               end
            end
            HDR: begin
               if (byte_done) begin
                  wr_en_n   = 1'b1;
                  wr_addr_n = count[ADDR_W-1:0];
                  wr_data_n = byte_val;
                  count_n   = count + CNT_ONE;
                  if (byte_val != mac_byte) state_n = DISCARD;
                  else if (count == CNT_LAST_HDR) state_n = BODY;
               end
               if (nss_rise) end_pend_n = 1'b1;
            end
            BODY: begin
               if (byte_done) begin
                  if (count == CNT_FULL) begin
                     state_n = DISCARD;
                  end else begin
                     wr_en_n   = 1'b1;
                     wr_addr_n = count[ADDR_W-1:0];
                     wr_data_n = byte_val;
                     count_n   = count + CNT_ONE;
                  end
               end
               if (nss_rise) end_pend_n = 1'b1;
            end
            DISCARD: begin
               if (nss_rise) end_pend_n = 1'b1;
            end
            default: state_n = WAIT_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_eth_recv_frontend.sv
// Testbench for eth_recv_frontend: frames are serialized onto the pins, the
// expected writes and end events come from a frame-level model, and a monitor
// pops and compares them as the DUT produces them.
module tb_eth_recv_frontend;

   localparam logic [47:0] TB_MAC    = 48'hEAEEF2F6FAFE;
   // Smaller buffer so the overflow frame stays short.
   localparam int          TB_ADDR_W = 8;
   localparam int          TB_BUF    = 256;

   logic                 clk;
   logic                 n_rst;
   logic                 recv_sck;
   logic                 recv_mosi;
   logic                 n_recv_ss;
   logic                 buf_full;
   logic                 wr_en;
   logic [TB_ADDR_W-1:0] wr_addr;
   logic [7:0]           wr_data;
   logic                 frame_done;
   logic [TB_ADDR_W-1:0] frame_len;
   logic                 frame_drop;

   eth_recv_frontend #(
      .MAC(TB_MAC),
      .ADDR_W(TB_ADDR_W),
      .BUF_SIZE(TB_BUF)
   ) dut (
      .clk(clk),
      .n_rst(n_rst),
      .recv_sck(recv_sck),
      .recv_mosi(recv_mosi),
      .n_recv_ss(n_recv_ss),
      .buf_full(buf_full),
      .wr_en(wr_en),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .frame_done(frame_done),
      .frame_len(frame_len),
      .frame_drop(frame_drop)
   );

   int total = 0;
   int bad   = 0;

   logic [7:0]           frame_bytes[$];
   logic [TB_ADDR_W+7:0] wq[$];
   logic [TB_ADDR_W:0]   eq[$];
   logic [47:0]          mac_v;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Frame-level reference: which bytes land in the buffer and how the frame ends.
   task automatic build_expect(input bit full, input int rst_at);
      bit ok;
      int n;
      ok = 1'b1;
      n  = frame_bytes.size();
      if (full) begin
         eq.push_back({1'b0, TB_ADDR_W'(0)});
         return;
      end
      for (int i = 0; i < n; i++) begin
         if (rst_at >= 0 && i == rst_at) return;
         if (i == TB_BUF) begin
            ok = 1'b0;
            break;
         end
         wq.push_back({TB_ADDR_W'(i), frame_bytes[i]});
         if (i < 6 && frame_bytes[i] != mac_v[8*i +: 8]) begin
            ok = 1'b0;
            break;
         end
      end
      if (rst_at >= 0) return;
      if (ok && n >= 6) eq.push_back({1'b1, TB_ADDR_W'(n - 1)});
      else eq.push_back({1'b0, TB_ADDR_W'(0)});
   endtask

   // Serialize frame_bytes onto the pins, optionally clearing buf_full after a
   // given byte, pulsing reset inside a given byte and appending stray bits.
   task automatic apply_stimulus(input bit start_full, input int clear_at, input int rst_at,
                                 input int partial);
      logic [7:0] b;
      build_expect(start_full, rst_at);
      buf_full  = start_full;
      n_recv_ss = 1'b0;
      tick(4);
      for (int k = 0; k < frame_bytes.size(); k++) begin
         b = frame_bytes[k];
         for (int i = 0; i < 8; i++) begin
            if (k == rst_at && i == 4) begin
               n_rst = 1'b0;
               #2;
               check_output("rst_wr_en", 32'(wr_en), 32'd0);
               check_output("rst_wr_addr", 32'(wr_addr), 32'd0);
               check_output("rst_wr_data", 32'(wr_data), 32'd0);
               check_output("rst_done", 32'(frame_done), 32'd0);
               tick(2);
               n_rst = 1'b1;
            end
            recv_mosi = b[i];
            tick($urandom_range(3, 4));
            recv_sck = 1'b1;
            tick($urandom_range(3, 4));
            recv_sck = 1'b0;
         end
         if (k == clear_at) buf_full = 1'b0;
      end
      for (int i = 0; i < partial; i++) begin
         recv_mosi = 1'($urandom_range(0, 1));
         tick(3);
         recv_sck = 1'b1;
         tick(3);
         recv_sck = 1'b0;
      end
      tick(2);
      n_recv_ss = 1'b1;
      tick(12);
      check_output("writes_left", 32'(wq.size()), 32'd0);
      check_output("ends_left", 32'(eq.size()), 32'd0);
      wq.delete();
      eq.delete();
      buf_full = 1'b0;
   endtask

   task automatic load_mac_frame(input int n);
      frame_bytes.delete();
      for (int i = 0; i < n; i++) begin
         if (i < 6) frame_bytes.push_back(mac_v[8*i +: 8]);
         else frame_bytes.push_back(8'($urandom_range(0, 255)));
      end
   endtask

   // Monitor: every write strobe and every end pulse is matched against the
   // oldest outstanding expectation.
   always @(negedge clk) begin
      logic [TB_ADDR_W+7:0] w;
      logic [TB_ADDR_W:0]   e;
      if (wr_en) begin
         if (wq.size() == 0) begin
            check_output("unexpected_write", {wr_addr, wr_data}, 32'hFFFFFFFF);
         end else begin
            w = wq.pop_front();
            check_output("write_addr_data", 32'({wr_addr, wr_data}), 32'(w));
         end
      end
      if (frame_done || frame_drop) begin
         if (eq.size() == 0) begin
            check_output("unexpected_end", {frame_done, frame_drop}, 32'hFFFFFFFF);
         end else begin
            e = eq.pop_front();
            check_output("end_kind", {frame_done, frame_drop}, {e[TB_ADDR_W], ~e[TB_ADDR_W]});
            if (e[TB_ADDR_W]) check_output("frame_len", 32'(frame_len), 32'(e[TB_ADDR_W-1:0]));
         end
      end
   end

   initial begin
      logic [7:0] plan[10];
      int         n;
      int         bad_idx;

      mac_v     = TB_MAC;
      n_rst     = 1'b0;
      recv_sck  = 1'b0;
      recv_mosi = 1'b0;
      n_recv_ss = 1'b1;
      buf_full  = 1'b0;
      tick(3);
      check_output("reset_wr_en", 32'(wr_en), 32'd0);
      check_output("reset_wr_addr", 32'(wr_addr), 32'd0);
      check_output("reset_wr_data", 32'(wr_data), 32'd0);
      check_output("reset_done", 32'(frame_done), 32'd0);
      check_output("reset_len", 32'(frame_len), 32'd0);
      check_output("reset_drop", 32'(frame_drop), 32'd0);
      n_rst = 1'b1;
      tick(6);

      plan = '{8'hFE, 8'hFA, 8'hF6, 8'hF2, 8'hEE, 8'hEA, 8'hAA, 8'h55, 8'h73, 8'h87};
      frame_bytes.delete();
      foreach (plan[i]) frame_bytes.push_back(plan[i]);
      apply_stimulus(1'b0, -1, -1, 0);

      frame_bytes[2] = 8'hF5;
      apply_stimulus(1'b0, -1, -1, 0);

      load_mac_frame(14);
      apply_stimulus(1'b1, 9, -1, 0);
      load_mac_frame(13);
      apply_stimulus(1'b0, -1, -1, 0);

      load_mac_frame(4);
      apply_stimulus(1'b0, -1, -1, 0);

      load_mac_frame(6);
      apply_stimulus(1'b0, -1, -1, 5);

      load_mac_frame(TB_BUF + 2);
      apply_stimulus(1'b0, -1, -1, 0);

      load_mac_frame(TB_BUF);
      apply_stimulus(1'b0, 3, -1, 0);

      load_mac_frame(12);
      apply_stimulus(1'b0, -1, 8, 0);
      load_mac_frame(10);
      apply_stimulus(1'b0, -1, -1, 0);

      for (int f = 0; f < 16; f++) begin
         n = $urandom_range(1, 20);
         load_mac_frame(n);
         if ($urandom_range(0, 3) == 0) begin
            bad_idx = $urandom_range(0, 5);
            if (bad_idx < n) frame_bytes[bad_idx] = frame_bytes[bad_idx] ^ (8'd1 << $urandom_range(0, 7));
         end
         apply_stimulus(($urandom_range(0, 4) == 0), $urandom_range(0, 8),
                        -1, ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
